hsc_adc_packer: RTL and testbench

HSC_ADC_PACKER -- requirements
Module: hsc_adc_packer

---
 rtl/hsc_adc_packer.sv | 185 ++++++++++++++++++
 tb/tb_hsc_adc_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsc_adc_packer.sv
// ADC byte stream to 32-bit word packer with optional level trigger.
// Drives a downstream write port with a load pulse, then one strobe per word.
module hsc_adc_packer #(
  parameter int LOAD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] frame_words,
  input  logic        trig_en,
  input  logic [7:0]  trig_level,
  input  logic [7:0]  adc_data,
  input  logic        adc_valid,
  output logic        wr_load,
  output logic        wr_req,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [23:0] word_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  load_cnt;
  logic [23:0] fw_q;
  logic [7:0]  lvl_q;
  logic        te_q;
  logic [1:0]  idx;
  logic [7:0]  prev;
  logic [23:0] pack;
  logic [23:0] wc_q;
  logic [23:0] wc_inc;
  logic        wr_req_q;
  logic [31:0] wr_data_q;

  logic start_ok;
  logic load_end;
  logic trig_hit;
  logic accept;
  logic word_end;

  assign wc_inc = wc_q + 24'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle control strobes; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    load_end = 1'b0;
    trig_hit = 1'b0;
    accept   = 1'b0;
    word_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && frame_words != 24'd0) begin
          start_ok = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (load_cnt == LOAD_LAST) begin
          load_end = 1'b1;
          state_d  = te_q ? ARM : CAPTURE;
        end
      end
      ARM: begin
        if (adc_valid && prev < lvl_q && adc_data >= lvl_q) begin
          trig_hit = 1'b1;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (adc_valid) begin
          accept = 1'b1;
          if (idx == 2'd3) begin
            word_end = 1'b1;
            if (wc_inc == fw_q) state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      start_ok = 1'b0;
      load_end = 1'b0;
      trig_hit = 1'b0;
      accept   = 1'b0;
      word_end = 1'b0;
    end
  end

  // Frame parameters captured on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw_q  <= '0;
      lvl_q <= '0;
      te_q  <= 1'b0;
    end else if (start_ok) begin
      fw_q  <= frame_words;
      lvl_q <= trig_level;
      te_q  <= trig_en;
    end
  end

  // Load pulse length counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               load_cnt <= '0;
    else if (start_ok)        load_cnt <= '0;
    else if (state_q == LOAD) load_cnt <= load_cnt + 4'd1;
  end

  // Previous valid sample for edge detection while armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prev <= 8'hFF;
    else if (load_end)
      prev <= 8'hFF;
    else if (state_q == ARM && adc_valid && !abort)
      prev <= adc_data;
  end

  // Byte lane packing; the trigger sample lands in lane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      pack <= '0;
    end else if (abort || start_ok) begin
      idx <= '0;
    end else if (trig_hit) begin
      pack[7:0] <= adc_data;
      idx       <= 2'd1;
    end else if (accept) begin
      idx <= idx + 2'd1;
      unique case (idx)
        2'd0: pack[7:0]   <= adc_data;
        2'd1: pack[15:8]  <= adc_data;
        2'd2: pack[23:16] <= adc_data;
        default: ;
      endcase
    end
  end

  // Word output strobe, data and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_q  <= 1'b0;
      wr_data_q <= '0;
      wc_q      <= '0;
    end else begin
      wr_req_q <= word_end;
      if (word_end) begin
        wr_data_q <= {adc_data, pack};
        wc_q      <= wc_inc;
      end else if (start_ok) begin
        wc_q <= '0;
      end
    end
  end

  assign wr_load  = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign wr_req   = wr_req_q;
  assign wr_data  = wr_data_q;
  assign word_cnt = wc_q;

endmodule

// File: tb/tb_hsc_adc_packer.sv
// Directed bench for hsc_adc_packer: vector table plus corner sequences.
// Expected words are hand-computed little-endian packings.
module tb_hsc_adc_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] frame_words = '0;
  logic        trig_en = 1'b0;
  logic [7:0]  trig_level = '0;
  logic [7:0]  adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        wr_load;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [23:0] word_cnt;

  hsc_adc_packer #(.LOAD_CYCLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .frame_words(frame_words),
    .trig_en(trig_en),
    .trig_level(trig_level),
    .adc_data(adc_data),
    .adc_valid(adc_valid),
    .wr_load(wr_load),
    .wr_req(wr_req),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [23:0] fw;
    logic        av;
    logic [7:0]  ad;
    logic        ab;
    logic        e_load;
    logic        e_req;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_done;
    logic [23:0] e_wc;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  logic [31:0] words[$];
  int n_done = 0;
  int n_overlap = 0;

  always @(negedge clk) begin
    if (wr_req) words.push_back(wr_data);
    if (done) n_done++;
    if (wr_req && wr_load) n_overlap++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [23:0] fw,
                     input logic av, input logic [7:0] ad,
                     input logic ab, input logic el, input logic er,
                     input logic [31:0] ed, input logic eb,
                     input logic edn, input logic [23:0] ew);
    vec_t v;
    v.st = st; v.fw = fw; v.av = av; v.ad = ad; v.ab = ab;
    v.e_load = el; v.e_req = er; v.e_data = ed;
    v.e_busy = eb; v.e_done = edn; v.e_wc = ew;
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [23:0] fw, input logic te,
                    input logic [7:0] lvl, output int nload);
    start = 1'b1;
    frame_words = fw;
    trig_en = te;
    trig_level = lvl;
    adc_valid = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    nload = wr_load ? 1 : 0;
    for (int i = 0; i < 20 && wr_load; i++) begin
      cyc(1'b0, 8'h00);
      if (wr_load) nload++;
    end
  endtask

  initial begin
    int nl;
    int base;
    int dn;

    // Frame of two words, no trigger; start while busy and zero-length
    // start are both ignored; a byte offered during LOAD is dropped.
    add(1, 24'd2, 0, 8'h00, 0, 1, 0, 32'h0,        1, 0, 24'd0);
    add(1, 24'd7, 0, 8'h00, 0, 1, 0, 32'h0,        1, 0, 24'd0);
    add(0, 24'd0, 0, 8'h00, 0, 1, 0, 32'h0,        1, 0, 24'd0);
    add(0, 24'd0, 0, 8'h00, 0, 1, 0, 32'h0,        1, 0, 24'd0);
    add(0, 24'd0, 1, 8'hEE, 0, 0, 0, 32'h0,        1, 0, 24'd0);
    add(0, 24'd0, 1, 8'h01, 0, 0, 0, 32'h0,        1, 0, 24'd0);
    add(0, 24'd0, 1, 8'h02, 0, 0, 0, 32'h0,        1, 0, 24'd0);
    add(0, 24'd0, 1, 8'h03, 0, 0, 0, 32'h0,        1, 0, 24'd0);
    add(0, 24'd0, 1, 8'h04, 0, 0, 1, 32'h04030201, 1, 0, 24'd1);
    add(0, 24'd0, 1, 8'h05, 0, 0, 0, 32'h04030201, 1, 0, 24'd1);
    add(0, 24'd0, 1, 8'h06, 0, 0, 0, 32'h04030201, 1, 0, 24'd1);
    add(0, 24'd0, 1, 8'h07, 0, 0, 0, 32'h04030201, 1, 0, 24'd1);
    add(0, 24'd0, 1, 8'h08, 0, 0, 1, 32'h08070605, 1, 1, 24'd2);
    add(0, 24'd0, 0, 8'h00, 0, 0, 0, 32'h08070605, 0, 0, 24'd2);
    add(1, 24'd0, 1, 8'h09, 0, 0, 0, 32'h08070605, 0, 0, 24'd2);
    add(1, 24'd3, 0, 8'h00, 1, 0, 0, 32'h08070605, 0, 0, 24'd2);

    // Reset state.
    #12;
    chk("rst_wr_load", 32'(wr_load), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      start = tbl[i].st;
      frame_words = tbl[i].fw;
      trig_en = 1'b0;
      adc_valid = tbl[i].av;
      adc_data = tbl[i].ad;
      abort = tbl[i].ab;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wr_load", i), 32'(wr_load), 32'(tbl[i].e_load));
      chk($sformatf("v%0d_wr_req", i), 32'(wr_req), 32'(tbl[i].e_req));
      chk($sformatf("v%0d_wr_data", i), wr_data, tbl[i].e_data);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("v%0d_word_cnt", i), 32'(word_cnt), 32'(tbl[i].e_wc));
    end
    start = 1'b0;
    abort = 1'b0;
    adc_valid = 1'b0;

    // Level trigger: capture begins at the first upward crossing.
    base = words.size();
    dn = n_done;
    go(24'd1, 1'b1, 8'h80, nl);
    chk("trig_load_len", 32'(nl), 32'd4);
    cyc(1'b1, 8'h10);
    cyc(1'b1, 8'h70);
    chk("trig_armed_busy", 32'(busy), 32'd1);
    cyc(1'b1, 8'h90);
    cyc(1'b1, 8'hA0);
    cyc(1'b1, 8'hB0);
    cyc(1'b1, 8'hC0);
    chk("trig_done", 32'(done), 32'd1);
    cyc(1'b0, 8'h00);
    chk("trig_nwords", 32'(words.size() - base), 32'd1);
    chk("trig_word", words[base], 32'hC0B0A090);
    chk("trig_wc", 32'(word_cnt), 32'd1);
    chk("trig_idle", 32'(busy), 32'd0);

    // Valid every other cycle, three words.
    base = words.size();
    dn = n_done;
    go(24'd3, 1'b0, 8'h00, nl);
    for (int b = 1; b <= 12; b++) begin
      cyc(1'b1, 8'(b));
      cyc(1'b0, 8'hAA);
    end
    chk("gap_nwords", 32'(words.size() - base), 32'd3);
    chk("gap_w0", words[base], 32'h04030201);
    chk("gap_w1", words[base + 1], 32'h08070605);
    chk("gap_w2", words[base + 2], 32'h0C0B0A09);
    chk("gap_done", 32'(n_done - dn), 32'd1);
    chk("gap_wc", 32'(word_cnt), 32'd3);
    chk("gap_idle", 32'(busy), 32'd0);

    // Abort after six bytes of a four word frame.
    base = words.size();
    dn = n_done;
    go(24'd4, 1'b0, 8'h00, nl);
    for (int b = 0; b < 6; b++) cyc(1'b1, 8'(8'h11 + b));
    abort = 1'b1;
    cyc(1'b1, 8'h17);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wc", 32'(word_cnt), 32'd1);
    cyc(1'b1, 8'h18);
    chk("abort_nwords", 32'(words.size() - base), 32'd1);
    chk("abort_word", words[base], 32'h14131211);
    chk("abort_no_done", 32'(n_done - dn), 32'd0);

    // Abort on the cycle a word would complete suppresses its strobe.
    base = words.size();
    go(24'd4, 1'b0, 8'h00, nl);
    cyc(1'b1, 8'h31);
    cyc(1'b1, 8'h32);
    cyc(1'b1, 8'h33);
    abort = 1'b1;
    cyc(1'b1, 8'h34);
    abort = 1'b0;
    chk("supp_wr_req", 32'(wr_req), 32'd0);
    chk("supp_wc", 32'(word_cnt), 32'd0);
    chk("supp_nwords", 32'(words.size() - base), 32'd0);

    // A fresh start after abort runs a full frame.
    base = words.size();
    dn = n_done;
    go(24'd1, 1'b0, 8'h00, nl);
    for (int b = 0; b < 4; b++) cyc(1'b1, 8'(8'h21 + b));
    cyc(1'b0, 8'h00);
    chk("restart_word", words[base], 32'h24232221);
    chk("restart_done", 32'(n_done - dn), 32'd1);
    chk("restart_wc", 32'(word_cnt), 32'd1);

    // Reset mid-capture clears outputs at once and kills the frame.
    base = words.size();
    go(24'd2, 1'b0, 8'h00, nl);
    for (int b = 0; b < 5; b++) cyc(1'b1, 8'(8'h41 + b));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_wr_load", 32'(wr_load), 32'd0);
    chk("mrst_wr_req", 32'(wr_req), 32'd0);
    chk("mrst_wr_data", wr_data, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_word_cnt", 32'(word_cnt), 32'd0);
    cyc(1'b1, 8'h46);
    cyc(1'b1, 8'h47);
    rst_n = 1'b1;
    for (int b = 0; b < 6; b++) cyc(1'b1, 8'(8'h50 + b));
    chk("mrst_nwords", 32'(words.size() - base), 32'd1);
    chk("mrst_idle", 32'(busy), 32'd0);
    adc_valid = 1'b0;

    chk("load_req_overlap", 32'(n_overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
